// File: rtl/fpmult_rr_scheduler.sv
// Round-robin front end sharing one stall-free pipelined FP32 multiplier among
// NUM_REQ requesters; a tag pipe tracks result ownership.
module fpmult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [32*NUM_REQ-1:0] req_a_i,
    input  logic [32*NUM_REQ-1:0] req_b_i,
    input  logic                  drain_i,
    output logic [31:0]           mul_a_o,
    output logic [31:0]           mul_b_o,
    input  logic [31:0]           mul_result_i,
    input  logic [4:0]            mul_flags_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_result_o,
    output logic [4:0]            rsp_flags_o,
    output logic                  idle_o,
    output logic [31:0]           ops_issued_o
);

    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          iss_v_q, iss_v_d;
    logic [IDX_W-1:0]              iss_idx_q, iss_idx_d;
    logic [31:0]                   mul_a_q, mul_a_d;
    logic [31:0]                   mul_b_q, mul_b_d;
    logic [MUL_LAT-1:0]            tag_v_q, tag_v_d;
    logic [MUL_LAT-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [31:0]                   rsp_result_q, rsp_result_d;
    logic [4:0]                    rsp_flags_q, rsp_flags_d;
    logic [31:0]                   ops_q, ops_d;

    logic                          grant_vld;
    logic [IDX_W-1:0]              grant_idx;
    logic [IDX_W:0]                cand;

    // Scan from rr_ptr upward; walking k downward lets the nearest eligible win.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ))
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            if (!rst && !drain_i && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Ready is only raised on a valid port, so a grant is an accept.
    assign req_ready_o = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        iss_v_d   = grant_vld;
        iss_idx_d = iss_idx_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        ops_d     = ops_q;
        if (grant_vld) begin
            rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            iss_idx_d = grant_idx;
            mul_a_d   = req_a_i[32*int'(grant_idx) +: 32];
            mul_b_d   = req_b_i[32*int'(grant_idx) +: 32];
            ops_d     = ops_q + 32'd1;
        end
    end

    // Tag pipe mirrors the multiplier depth so the last stage lines up with its result.
    always_comb begin
        tag_v_d      = tag_v_q;
        tag_idx_d    = tag_idx_q;
        tag_v_d[0]   = iss_v_q;
        tag_idx_d[0] = iss_idx_q;
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_v_d[k]   = tag_v_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end
    end

    always_comb begin
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (tag_v_q[MUL_LAT-1]) begin
            rsp_valid_d  = NUM_REQ'(1) << tag_idx_q[MUL_LAT-1];
            rsp_result_d = mul_result_i;
            rsp_flags_d  = mul_flags_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            iss_v_q      <= 1'b0;
            iss_idx_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            tag_v_q      <= '0;
            tag_idx_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            ops_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            iss_v_q      <= iss_v_d;
            iss_idx_q    <= iss_idx_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            tag_v_q      <= tag_v_d;
            tag_idx_q    <= tag_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            ops_q        <= ops_d;
        end
    end

    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign ops_issued_o = ops_q;
    assign idle_o       = !iss_v_q && !(|tag_v_q) && !(|rsp_valid_q);

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// Bench for fpmult_rr_scheduler: stand-in pipelined multiplier, queue-based
// scheduler model checked every cycle, plus directed literal checks.
module tb_fpmult_rr_scheduler;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic            drain;
    logic [31:0]     mul_a, mul_b, mul_result;
    logic [4:0]      mul_flags;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_result;
    logic [4:0]      rsp_flags;
    logic            idle;
    logic [31:0]     ops_issued;

    always #5 clk = ~clk;

    fpmult_rr_scheduler #(.NUM_REQ(N), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .drain_i(drain),
        .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_result_i(mul_result), .mul_flags_i(mul_flags),
        .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
        .idle_o(idle), .ops_issued_o(ops_issued)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Simplified FP32 multiply returning {flags[NV,DZ,OF,UF,NX], result}.
    // Denormals are flushed to zero and the mantissa is truncated.
    function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        logic        nx;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {5'b10000, 32'h7FC00000};
        if ((ea == 255 && b[30:0] == 0) || (eb == 255 && a[30:0] == 0)) return {5'b10000, 32'h7FC00000};
        if (ea == 255 || eb == 255) return {5'b00000, s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {5'b00000, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p[47]) begin
            e++;
            m  = p[46:24];
            nx = |p[23:0];
        end else begin
            m  = p[45:23];
            nx = |p[22:0];
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        if (e <= 0) return {5'b00011, s, 31'd0};
        return {4'b0000, nx, s, e[7:0], m};
    endfunction

    // Stand-in multiplier: LAT register stages, result combinational off the last.
    logic [36:0] mp_q [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) mp_q[k] <= '0;
        end else begin
            mp_q[0] <= fmul(mul_a, mul_b);
            for (int k = 1; k < LAT; k++) mp_q[k] <= mp_q[k-1];
        end
    end
    assign {mul_flags, mul_result} = mp_q[LAT-1];

    // Model: transaction queue keyed by the cycle each response is due.
    typedef struct {
        int          due;
        int          port;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          m_ptr = 0;
    logic [31:0] m_ops = '0;
    logic [31:0] m_mul_a = '0, m_mul_b = '0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_flg = '0;
    bit          armed = 0;

    always @(negedge clk) begin : model
        int          g;
        logic [N-1:0] e_ready, e_rv;
        logic [36:0] r;
        exp_t        t;
        g = -1;
        if (!rst && !drain)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rv = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rv[q[0].port] = 1'b1;
            r = fmul(q[0].a, q[0].b);
            m_res = r[31:0];
            m_flg = r[36:32];
        end
        if (armed) begin
            chk("ready", 64'(req_ready), 64'(e_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("rsp_result", 64'(rsp_result), 64'(m_res));
            chk("rsp_flags", 64'(rsp_flags), 64'(m_flg));
            chk("idle", 64'(idle), 64'(q.size() == 0));
            chk("mul_a", 64'(mul_a), 64'(m_mul_a));
            chk("mul_b", 64'(mul_b), 64'(m_mul_b));
            chk("ops_issued", 64'(ops_issued), 64'(m_ops));
        end
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        if (rst) begin
            q.delete();
            m_ptr = 0; m_ops = '0; m_mul_a = '0; m_mul_b = '0; m_res = '0; m_flg = '0;
            armed = 1;
        end else if (g >= 0) begin
            t.due = cyc + LAT + 2;
            t.port = g;
            t.a = req_a[32*g +: 32];
            t.b = req_b[32*g +: 32];
            q.push_back(t);
            m_ptr = (g + 1) % N;
            m_ops = m_ops + 32'd1;
            m_mul_a = t.a;
            m_mul_b = t.b;
        end
        cyc++;
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b);
        req_a[32*p +: 32] = a;
        req_b[32*p +: 32] = b;
    endtask

    initial begin
        int cnt, last, first_idle;
        rst = 1'b1; req_valid = '0; drain = 1'b0; req_a = '0; req_b = '0;
        repeat (2) drv();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_ops", 64'(ops_issued), 64'd0);
        chk("reset_mul_a", 64'(mul_a), 64'd0);

        // Single op on port 2: 2.0 * 3.0.
        drv();
        set_port(2, 32'h40000000, 32'h40400000);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'h4);
        drv();
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("single_result", 64'(rsp_result), 64'h40C00000);
        chk("single_flags", 64'(rsp_flags), 64'd0);

        // All ports valid from reset; ready must be low in the reset cycle.
        set_port(0, 32'h3F800000, 32'h3F800000);
        set_port(1, 32'h40000000, 32'h40000000);
        set_port(3, 32'h3FC00000, 32'h3FC00000);
        drv();
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        drv();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
            drv();
        end
        req_valid = '0;
        @(negedge clk);
        chk("ops_after_8", 64'(ops_issued), 64'd8);

        // Fairness: move pointer to 2 with a lone port-1 grant, then 1 and 3 contend.
        drv();
        req_valid = 4'b0010;
        drv();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fair_grant", 64'(req_ready), (i % 2 == 0) ? 64'h8 : 64'h2);
            drv();
        end
        req_valid = '0;
        repeat (8) drv();

        // Drain after three back-to-back accepts.
        req_valid = 4'b1111;
        repeat (3) drv();
        drain = 1'b1;
        cnt = 0; last = -1; first_idle = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_ready", 64'(req_ready), 64'd0);
            if (rsp_valid != '0) begin cnt++; last = i; end
            if (idle && first_idle < 0) first_idle = i;
            drv();
        end
        chk("drain_pulses", 64'(cnt), 64'd3);
        chk("drain_idle_cycle", 64'(first_idle), 64'(last + 1));
        drain = 1'b0;
        req_valid = '0;

        // Reset one cycle after an accept discards the op.
        drv();
        req_valid = 4'b0001;
        drv();
        req_valid = '0;
        rst = 1'b1;
        drv();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 64'(idle), 64'd1);
        chk("midrst_ops", 64'(ops_issued), 64'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid != '0) cnt++;
            @(negedge clk);
        end
        chk("midrst_no_rsp", 64'(cnt), 64'd0);

        // +inf * 0 on port 1: invalid flag routed to port 1 only.
        drv();
        set_port(1, 32'h7F800000, 32'h00000000);
        req_valid = 4'b0010;
        drv();
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("flags_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("flags_nv", 64'(rsp_flags), 64'h10);
        chk("flags_result", 64'(rsp_result), 64'h7FC00000);

        repeat (4) drv();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
